// File: rtl/muldiv_control_sequencer.sv
// Control sequencer for three-register ALU ops and MUL/DIV into HI/LO.
// Optional CU_SINGLE_STEP_EN adds a Step input gating instruction start in T0.
module muldiv_control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic        MemReady,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  ALUop,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Illegal,
  output logic        Done
);

  localparam logic [2:0] T0   = 3'd0;
  localparam logic [2:0] T1   = 3'd1;
  localparam logic [2:0] T2   = 3'd2;
  localparam logic [2:0] T3   = 3'd3;
  localparam logic [2:0] T4   = 3'd4;
  localparam logic [2:0] T5   = 3'd5;
  localparam logic [2:0] T6   = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic [2:0] state_q, state_d;
  logic       wait_q, wait_d;
  logic       illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, legal, go;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (opcode <= 5'd12);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign legal     = is_alu || is_muldiv;

`ifdef CU_SINGLE_STEP_EN
  assign go = Run & Step;
`else
  assign go = Run;
`endif

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= T0;
      wait_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  // wait_q marks T1 cycles after the first, so PCin/Zlowout fire only once.
  always_comb begin
    state_d   = state_q;
    wait_d    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      T0: if (go) state_d = T1;
      T1: begin
        if (MemReady) state_d = T2;
        else          wait_d  = 1'b1;
      end
      T2: state_d = T3;
      T3: begin
        if (legal) begin
          state_d = T4;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      T4: state_d = T5;
      T5: state_d = is_muldiv ? T6 : T0;
      T6: state_d = T0;
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    ALUop    = '0;
    Rout     = '0;
    Rin      = '0;
    Illegal  = 1'b0;
    Done     = 1'b0;
    // Outputs are forced quiet while Clear is high, whatever the state.
    if (!Clear) begin
      Illegal = illegal_q;
      case (state_q)
        T0: begin
          if (go) begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            ZLowIn = 1'b1;
          end
        end
        T1: begin
          Read  = 1'b1;
          MDRin = MemReady;
          if (!wait_q) begin
            PCin    = 1'b1;
            Zlowout = 1'b1;
          end
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          if (is_alu) begin
            Yin  = 1'b1;
            Rout = onehot(rb);
          end else if (is_muldiv) begin
            Yin  = 1'b1;
            Rout = onehot(ra);
          end else begin
            Illegal = 1'b1;
          end
        end
        T4: begin
          ALUop   = opcode;
          ZLowIn  = 1'b1;
          ZHighIn = is_muldiv;
          Rout    = is_muldiv ? onehot(rb) : onehot(rc);
        end
        T5: begin
          Zlowout = 1'b1;
          if (is_muldiv) begin
            LOin = 1'b1;
          end else begin
            Rin  = onehot(ra);
            Done = 1'b1;
          end
        end
        T6: begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
          Done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_control_sequencer.sv
// Self-checking bench: per-cycle strobe vectors compared against a step-table
// reference built from the instruction fields; define CU_SINGLE_STEP_EN to test Step.
module tb_muldiv_control_sequencer;

  typedef struct packed {
    logic pcout, pcin, incpc, marin, read, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, done, illegal;
    logic [4:0]  aluop;
    logic [15:0] rout;
    logic [15:0] rin;
  } obs_t;

  logic        Clock = 1'b0;
  logic        Clear, Run, MemReady, Step;
  logic [31:0] IR;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin, Illegal, Done;
  logic [4:0]  ALUop;
  logic [15:0] Rout, Rin;
  obs_t        obs;

  int compared   = 0;
  int mismatched = 0;

  always #5 Clock = ~Clock;

  muldiv_control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .MemReady(MemReady),
`ifdef CU_SINGLE_STEP_EN
    .Step(Step),
`endif
    .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .ALUop(ALUop), .Rout(Rout), .Rin(Rin),
    .Illegal(Illegal), .Done(Done)
  );

  always_comb obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin,
                     ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin, Done, Illegal,
                     ALUop, Rout, Rin};

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic step_chk(input string tag, input obs_t exp);
    @(negedge Clock);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic step_nochk();
    @(posedge Clock);
    #1;
  endtask

  function automatic obs_t fetch0();
    obs_t e = '0;
    e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zlowin = 1'b1;
    return e;
  endfunction

  // Runs one instruction from T0 with `waits` not-ready cycles in T1.
  // Illegal opcodes end parked in HALT after `halt_cycles` checked cycles.
  task automatic run_instr(input string tag, input logic [31:0] ir,
                           input int unsigned waits, input int unsigned halt_cycles);
    obs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic muldiv, legal;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    muldiv = (op == 5'd15) || (op == 5'd16);
    legal  = (op <= 5'd12) || muldiv;
    IR = ir; Run = 1'b1; Step = 1'b1; MemReady = 1'(($urandom % 2));
    step_chk({tag, "_T0"}, fetch0());
    for (int unsigned w = 0; w <= waits; w++) begin
      Run = 1'($urandom % 2);
      MemReady = (w == waits);
      e = '0; e.read = 1'b1;
      if (w == 0) begin e.pcin = 1'b1; e.zlowout = 1'b1; end
      if (w == waits) e.mdrin = 1'b1;
      step_chk({tag, "_T1"}, e);
    end
    MemReady = 1'(($urandom % 2));
    e = '0; e.mdrout = 1'b1; e.irin = 1'b1;
    step_chk({tag, "_T2"}, e);
    if (!legal) begin
      Run = 1'b1;
      e = '0; e.illegal = 1'b1;
      step_chk({tag, "_T3ill"}, e);
      for (int unsigned h = 0; h < halt_cycles; h++) step_chk({tag, "_HALT"}, e);
      return;
    end
    e = '0; e.yin = 1'b1; e.rout = 16'd1 << (muldiv ? ra : rb);
    step_chk({tag, "_T3"}, e);
    e = '0; e.aluop = op; e.zlowin = 1'b1; e.zhighin = muldiv;
    e.rout = 16'd1 << (muldiv ? rb : rc);
    step_chk({tag, "_T4"}, e);
    e = '0; e.zlowout = 1'b1;
    if (muldiv) e.loin = 1'b1;
    else begin e.rin = 16'd1 << ra; e.done = 1'b1; end
    step_chk({tag, "_T5"}, e);
    if (muldiv) begin
      e = '0; e.zhighout = 1'b1; e.hiin = 1'b1; e.done = 1'b1;
      step_chk({tag, "_T6"}, e);
    end
  endtask

  task automatic do_clear(input string tag);
    Clear = 1'b1; Run = 1'b1;
    step_chk({tag, "_during"}, '0);
    Clear = 1'b0; Run = 1'b0;
    step_chk({tag, "_after"}, '0);
  endtask

  initial begin
    logic [4:0] op;
    logic [31:0] rir;
    int unsigned r;
    Clear = 1'b1; Run = 1'b0; MemReady = 1'b0; Step = 1'b1; IR = '0;
    step_nochk();
    step_chk("reset_during", '0);
    Clear = 1'b0;
    step_chk("reset_idle", '0);

    // Clear held two cycles while in T4 aborts cleanly.
    IR = 32'h28918000; Run = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) step_nochk();
    Clear = 1'b1;
    step_chk("clrT4_c1", '0);
    step_chk("clrT4_c2", '0);
    Clear = 1'b0; Run = 1'b0;
    step_chk("clrT4_after", '0);

    // Clear during a T1 wait.
    Run = 1'b1; MemReady = 1'b0;
    step_nochk(); step_nochk(); step_nochk();
    do_clear("clrT1");

    run_instr("mul", 32'h7A280000, 0, 0);
    run_instr("and", 32'h28918000, 0, 0);
    Run = 1'b0;
    step_chk("idle_after_and", '0);
    run_instr("memwait", 32'h28918000, 3, 0);
    run_instr("div", {5'b10000, 4'd15, 4'd0, 4'd7, 15'h1234}, 1, 0);

    run_instr("ill31", {5'b11111, 27'h5A5A5A5}, 0, 4);
    do_clear("ill31_clr");
    r  = $urandom_range(0, 16);
    op = (r < 2) ? 5'(13 + r) : 5'(15 + r);
    run_instr("illrnd", {op, 27'($urandom)}, $urandom_range(0, 2), 2);
    do_clear("illrnd_clr");

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 14);
      op = (r <= 12) ? 5'(r) : ((r == 13) ? 5'd15 : 5'd16);
      rir = {op, 27'($urandom)};
      run_instr("rnd", rir, $urandom_range(0, 3), 0);
      if ($urandom % 3 == 0) begin
        Run = 1'b0; MemReady = 1'($urandom % 2);
        step_chk("rnd_idle", '0);
      end
    end

`ifdef CU_SINGLE_STEP_EN
    run_instr("ss_and", 32'h28918000, 0, 0);
    Step = 1'b0; Run = 1'b1;
    for (int i = 0; i < 10; i++) step_chk("ss_hold", '0);
    Step = 1'b1;
    step_chk("ss_go", fetch0());
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
